aud_trace_ctrl: RTL and testbench

//  Capture sequencer for the AUD branch-trace receiver. Takes the one-cycle-per-address

---
 rtl/aud_trace_ctrl.sv | 152 +++++++++++++++
 tb/tb_aud_trace_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/aud_trace_ctrl.sv
// AUD branch-trace capture sequencer.
// Arm/trigger/post-trigger session feeding a FWFT event FIFO.
module aud_trace_ctrl #(
  parameter int DEPTH_LOG2 = 4,
  parameter int POST_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctl_arm,
  input  logic                  ctl_stop,
  input  logic                  trig_en,
  input  logic [31:0]           trig_addr,
  input  logic [31:0]           trig_mask,
  input  logic [POST_W-1:0]     post_count,
  input  logic                  ev_stb,
  input  logic [31:0]           ev_addr,
  input  logic                  ev_valid,
  input  logic                  ev_buserr,
  output logic                  rd_valid,
  output logic [35:0]           rd_data,
  input  logic                  rd_ready,
  output logic [1:0]            state,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [15:0]           ovf_cnt,
  output logic                  done
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0] level, level_d;
  logic [POST_W-1:0]   cnt_q, cnt_d;
  logic [15:0]         ovf_q, ovf_d;
  logic                gap_q, gap_d;
  logic [35:0]         rd_data_q, rd_data_d;
  logic [35:0]         mem_q [DEPTH];

  logic        active, flush, hit, push_req;
  logic        pop, push_ok;
  logic [35:0] wdata;

  assign level      = wr_ptr_q - rd_ptr_q;
  assign rd_valid   = level != '0;
  assign rd_data    = rd_data_q;
  assign fifo_level = level;
  assign ovf_cnt    = ovf_q;
  assign state      = state_q;
  assign done       = state_q == S_DONE;

  // Event qualification: capture window, trigger match, push/pop grant.
  always_comb begin
    active   = (state_q == S_ARMED) || (state_q == S_POST);
    flush    = ctl_arm && !active;
    hit      = (state_q == S_ARMED) && trig_en && ev_stb &&
               ev_valid &&
               (((ev_addr ^ trig_addr) & trig_mask) == 32'd0);
    push_req = ev_stb && active;
    pop      = rd_valid && rd_ready && !flush;
    push_ok  = push_req && ((level != FULL) || pop);
    wdata    = {hit, gap_q, ev_buserr, ev_valid, ev_addr};
  end

  // FIFO pointers, overflow accounting and registered head data.
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ovf_d    = ovf_q;
    gap_d    = gap_q;
    if (push_req && !push_ok) begin
      gap_d = 1'b1;
      if (ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
    end else if (push_ok) begin
      gap_d = 1'b0;
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = '0;
      gap_d    = 1'b0;
    end
    level_d   = wr_ptr_d - rd_ptr_d;
    rd_data_d = rd_data_q;
    if (level_d != '0) begin
      if (push_ok && (rd_ptr_d == wr_ptr_q))
        rd_data_d = wdata;
      else
        rd_data_d = mem_q[rd_ptr_d[DEPTH_LOG2-1:0]];
    end
  end

  // Session sequencing and post-trigger countdown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (ctl_arm) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (ctl_stop) begin
          state_d = S_DONE;
        end else if (hit) begin
          cnt_d   = post_count;
          state_d = (post_count == '0) ? S_DONE : S_POST;
        end
      end
      S_POST: begin
        if (ev_stb) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == POST_W'(1)) state_d = S_DONE;
        end
        if (ctl_stop) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= '0;
      gap_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      gap_q     <= gap_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Entry storage; contents only read once written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wdata;
  end
endmodule

// File: tb/tb_aud_trace_ctrl.sv
// Testbench for aud_trace_ctrl.
// Queue-based reference model with scoreboard monitor.
module tb_aud_trace_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ctl_arm = 1'b0, ctl_stop = 1'b0;
  logic        trig_en = 1'b0;
  logic [31:0] trig_addr = '0, trig_mask = '0;
  logic [15:0] post_count = '0;
  logic        ev_stb = 1'b0, ev_valid = 1'b0, ev_buserr = 1'b0;
  logic [31:0] ev_addr = '0;
  logic        rd_valid, rd_ready = 1'b0;
  logic [35:0] rd_data;
  logic [1:0]  state;
  logic [4:0]  fifo_level;
  logic [15:0] ovf_cnt;
  logic        done;

  aud_trace_ctrl #(.DEPTH_LOG2(4), .POST_W(16)) dut (
    .clk(clk), .rst(rst),
    .ctl_arm(ctl_arm), .ctl_stop(ctl_stop),
    .trig_en(trig_en), .trig_addr(trig_addr),
    .trig_mask(trig_mask), .post_count(post_count),
    .ev_stb(ev_stb), .ev_addr(ev_addr),
    .ev_valid(ev_valid), .ev_buserr(ev_buserr),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_ready(rd_ready), .state(state),
    .fifo_level(fifo_level), .ovf_cnt(ovf_cnt),
    .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [35:0] sb[$];
  int ms = 0;
  int mcnt = 0;
  int movf = 0;
  bit mgap = 0;
  bit tb_flush = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Data monitor: every accepted head entry must match the scoreboard.
  always @(posedge clk) begin
    if (!rst && !tb_flush && rd_valid && rd_ready) begin
      if (sb.size() == 0) begin
        chk("pop_unexpected", 64'd1, 64'd0);
      end else begin
        chk("rd_data", 64'(rd_data), 64'(sb[0]));
        void'(sb.pop_front());
      end
    end
  end

  // Status monitor, sampled just after each edge.
  always @(posedge clk) begin
    #1;
    chk("level", 64'(fifo_level), 64'(sb.size()));
    chk("rd_valid", 64'(rd_valid), 64'(sb.size() != 0));
    chk("state", 64'(state), 64'(ms));
    chk("done", 64'(done), 64'(ms == 3));
    chk("ovf_cnt", 64'(ovf_cnt), 64'(movf));
  end

  // Drive one cycle and advance the model by the rules of a session.
  task automatic step(bit arm, bit stop, bit stb, logic [31:0] a,
                      bit v, bit be, bit rdy);
    bit act, flush, pop, hit;
    ctl_arm = arm; ctl_stop = stop; ev_stb = stb;
    ev_addr = a; ev_valid = v; ev_buserr = be; rd_ready = rdy;
    act   = (ms == 1) || (ms == 2);
    flush = arm && !act;
    tb_flush = flush;
    if (flush) begin
      sb.delete(); movf = 0; mgap = 0; ms = 1;
    end else begin
      pop = (sb.size() > 0) && rdy;
      hit = (ms == 1) && trig_en && stb && v &&
            (((a ^ trig_addr) & trig_mask) == 0);
      if (stb && act) begin
        if (sb.size() < 16 || pop) begin
          sb.push_back({hit, mgap, be, v, a});
          mgap = 0;
        end else begin
          if (movf < 65535) movf++;
          mgap = 1;
        end
      end
      if (ms == 1) begin
        if (stop) ms = 3;
        else if (hit) begin
          mcnt = post_count;
          ms = (post_count == 0) ? 3 : 2;
        end
      end else if (ms == 2) begin
        if (stb) begin
          mcnt--;
          if (mcnt == 0) ms = 3;
        end
        if (stop) ms = 3;
      end
    end
    @(posedge clk); #2;
  endtask

  task automatic ev(logic [31:0] a, bit rdy);
    step(0, 0, 1, a, 1, 0, rdy);
  endtask

  task automatic idle(bit rdy);
    step(0, 0, 0, 32'h0, 0, 0, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ctl_arm = 0; ctl_stop = 0; ev_stb = 0; rd_ready = 0;
    sb.delete(); ms = 0; movf = 0; mgap = 0; tb_flush = 0;
    #1;
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf", 64'(ovf_cnt), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  initial begin
    #1;
    do_reset();

    // continuous capture, three events, first-word latency
    trig_en = 0;
    step(1, 0, 0, 0, 0, 0, 0);
    ev(32'h1000, 0);
    chk("t1_latency", 64'(rd_valid), 64'd1);
    ev(32'h1004, 0);
    idle(0);
    ev(32'h2000, 0);
    chk("t1_level", 64'(fifo_level), 64'd3);
    repeat (4) idle(1);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("t1_stop", 64'(state), 64'd3);

    // masked trigger with two post-trigger events
    trig_en = 1; trig_addr = 32'h8000_0100;
    trig_mask = 32'hFFFF_FFF0; post_count = 2;
    step(1, 0, 0, 0, 0, 0, 0);
    ev(32'h10, 0);
    ev(32'h8000_0104, 0);
    chk("t2_post", 64'(state), 64'd2);
    ev(32'h20, 0);
    ev(32'h30, 0);
    ev(32'h40, 0);
    chk("t2_level", 64'(fifo_level), 64'd4);
    chk("t2_done", 64'(done), 64'd1);
    repeat (5) idle(1);

    // overflow, gap marking, full with simultaneous pop
    trig_en = 0;
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) ev(32'h100 + 4 * i, 0);
    chk("t3_level", 64'(fifo_level), 64'd16);
    chk("t3_ovf", 64'(ovf_cnt), 64'd4);
    repeat (3) idle(1);
    ev(32'hABC0, 0);
    ev(32'hABC4, 0);
    ev(32'hABC8, 0);
    chk("t4_full", 64'(fifo_level), 64'd16);
    ev(32'hABCC, 1);
    chk("t4_level", 64'(fifo_level), 64'd16);
    chk("t4_ovf", 64'(ovf_cnt), 64'd4);
    repeat (18) idle(1);
    step(0, 1, 0, 0, 0, 0, 0);

    // stop in POST with simultaneous event, then re-arm
    trig_en = 1; post_count = 5;
    step(1, 0, 0, 0, 0, 0, 0);
    ev(32'h8000_0100, 0);
    step(0, 1, 1, 32'h55, 1, 0, 0);
    chk("t5_state", 64'(state), 64'd3);
    chk("t5_level", 64'(fifo_level), 64'd2);
    step(1, 0, 0, 0, 0, 0, 1);
    chk("t5_arm_level", 64'(fifo_level), 64'd0);
    chk("t5_arm_ovf", 64'(ovf_cnt), 64'd0);
    chk("t5_arm_state", 64'(state), 64'd1);

    // reset mid-POST
    post_count = 10;
    ev(32'h8000_010C, 0);
    for (int i = 0; i < 4; i++) ev(32'h900 + i, 0);
    chk("t6_state", 64'(state), 64'd2);
    chk("t6_level", 64'(fifo_level), 64'd5);
    do_reset();
    ev(32'h777, 1);
    ev(32'h778, 1);
    chk("t6_ignored", 64'(fifo_level), 64'd0);

    // randomized sessions
    for (int i = 0; i < 1500; i++) begin
      int r;
      bit lowrdy;
      logic [31:0] a;
      if (i % 200 == 0) begin
        trig_en = 1'($urandom_range(0, 1));
        post_count = 16'($urandom_range(0, 6));
      end
      lowrdy = ((i / 300) % 2) == 1;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 3) == 0)
        a = 32'h8000_0100 | 32'($urandom_range(0, 31));
      else
        a = $urandom;
      step(r < 3, (r >= 3) && (r < 5), 1'($urandom_range(0, 1)), a,
           $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
           lowrdy ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0));
    end
    repeat (20) idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
